// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// timeout counter width and request-legality helpers.
package lsu_pkg;

    localparam int CNT_W = 8;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
        if (store) return (f3 > F3_SW);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // funct3[1:0] encodes access size for both loads and stores
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   return a[0];
            2'b10:   return (a != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and data replication, load lane
// selection with sign/zero extension. Sub-word offsets ignore misaligned low bits.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        case (i_funct3)
            F3_LB:   o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_rdata = {{16{w_half[15]}}, w_half};
            F3_LW:   o_rdata = i_rdata;
            F3_LBU:  o_rdata = {24'd0, w_byte};
            F3_LHU:  o_rdata = {16'd0, w_half};
            default: o_rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rv32i memory-access stage: one load/store per transaction over a req/ack bus.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned halves/words into error responses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        rsp_valid,
    output logic        rsp_we,
    output logic [4:0]  rsp_rd,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    lsu_state_e       r_state, w_next;
    logic             r_store, r_err;
    logic [2:0]       r_funct3;
    logic [1:0]       r_addr_lo;
    logic [4:0]       r_rd;
    logic [31:0]      r_rdata;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mem_req, r_mem_we;
    logic [31:0]      r_mem_addr, r_mem_wdata;
    logic [3:0]       r_mem_be;

    logic             w_bad, w_tmo;
    logic [2:0]       w_al_f3;
    logic [1:0]       w_al_lo;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata_rep, w_ext;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_bad = f3_illegal(req_store, req_funct3) | misaligned(req_funct3, req_addr[1:0]);
`else
    assign w_bad = f3_illegal(req_store, req_funct3);
`endif

    assign w_tmo = (r_cnt == CNT_W'(TIMEOUT - 1));

    // One aligner serves the incoming request in IDLE and the captured op afterwards
    assign w_al_f3 = (r_state == ST_IDLE) ? req_funct3    : r_funct3;
    assign w_al_lo = (r_state == ST_IDLE) ? req_addr[1:0] : r_addr_lo;

    lsu_align u_align (
        .i_funct3  (w_al_f3),
        .i_addr_lo (w_al_lo),
        .i_wdata   (req_wdata),
        .i_rdata   (mem_rdata),
        .o_be      (w_be),
        .o_wdata   (w_wdata_rep),
        .o_rdata   (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (req_valid) w_next = w_bad ? ST_RESP : ST_BUS;
            ST_BUS:  if (mem_ack || w_tmo) w_next = ST_RESP;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_store     <= 1'b0;
            r_err       <= 1'b0;
            r_funct3    <= 3'd0;
            r_addr_lo   <= 2'd0;
            r_rd        <= 5'd0;
            r_rdata     <= 32'd0;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_be    <= 4'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: if (req_valid) begin
                    r_store   <= req_store;
                    r_funct3  <= req_funct3;
                    r_addr_lo <= req_addr[1:0];
                    r_rd      <= req_rd;
                    r_err     <= w_bad;
                    r_rdata   <= 32'd0;
                    r_cnt     <= '0;
                    if (!w_bad) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= req_store;
                        r_mem_addr  <= {req_addr[31:2], 2'b00};
                        r_mem_be    <= w_be;
                        r_mem_wdata <= req_store ? w_wdata_rep : 32'd0;
                    end
                end
                ST_BUS: begin
                    if (mem_ack || w_tmo) begin
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= 32'd0;
                        r_mem_be    <= 4'd0;
                        r_mem_wdata <= 32'd0;
                    end
                    if (mem_ack)    r_rdata <= r_store ? 32'd0 : w_ext;
                    else if (w_tmo) r_err   <= 1'b1;
                    else            r_cnt   <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign stall     = !req_ready;
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_we    = rsp_valid && !r_store && !r_err;
    assign rsp_err   = rsp_valid && r_err;
    assign rsp_rd    = r_rd;
    assign rsp_rdata = rsp_valid ? r_rdata : 32'd0;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage of the rv32i pipeline. Accepts one load or store per transaction from the execute stage (effective address, funct3, store data, destination register), drives a simple request/acknowledge data-memory bus with byte enables, and returns the aligned and sign-/zero-extended load result for register writeback. It holds `stall` while a bus transaction is outstanding so the pipeline freezes. It replaces the constant-zero load result in the CPU top.

## Interface
- `TIMEOUT`, 16: max cycles `mem_req` may wait for `mem_ack` before the access is abandoned (≥1, ≤255).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset: one clock; reset is synchronous and active-high.
- `req_valid`  in  1  execute stage presents a memory op.
- `req_ready`  out  1  LSU can accept (state IDLE).
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3 of the load/store.
- `req_addr`  in  32  effective byte address.
- `req_wdata`  in  32  rs2 value for stores.
- `req_rd`  in  5  destination register for loads.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_we`  out  1  writeback enable (load completed without error).
- `rsp_rd`  out  5  captured `req_rd`.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  bad funct3, timeout, or (with macro) misalignment.
- `stall`  out  1  transaction in flight (`!req_ready`).
- `mem_req`  out  1  bus request, held until ack or timeout.
- `mem_we`  out  1  write strobe.
- `mem_addr`  out  32  word address (`addr[1:0]` forced 0).
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  bus completion; read data valid same cycle.
- `mem_rdata`  in  32  read word.

## Operation
- FSM: IDLE → BUS → RESP → IDLE; error path IDLE → RESP.
- IDLE: `req_ready`=1. On `req_valid`, capture store/funct3/addr/wdata/rd. Illegal funct3 (loads 011/110/111; stores ≥011) → RESP with err, no bus access. Else → BUS.
- BUS: `mem_req`=1, all bus outputs registered and stable. `mem_ack`=1 → latch `mem_rdata`, → RESP. Counter counts BUS cycles; reaching `TIMEOUT` with no ack → RESP with err.
- RESP: `rsp_valid`=1 for one cycle; `rsp_we` = load && !err; → IDLE.
- Store lanes: SB `be=0001<<a[1:0]`, wdata = byte×4; SH `be=0011<<{a[1],0}`, wdata = half×2; SW `be=1111`.
- Load extraction: LB/LBU select byte `a[1:0]`, LH/LHU select half `a[1]`; sign-extend for LB/LH, zero-extend for LBU/LHU; LW passes the word.
- `mem_ack` is ignored outside BUS (late ack after timeout is dropped).

## Timing
- Reset: state IDLE, every output 0 except `req_ready`=1; counter 0. Reset mid-BUS drops `mem_req` at the next edge with no response.
- Accept at edge N; `mem_req` high from N+1; ack sampled at edge K (K ≥ N+1, zero-wait allowed) → `rsp_valid` during cycle K+1; `req_ready` high again cycle K+2. Minimum latency accept→rsp = 2 cycles.
- Error (funct3/misalign): `rsp_valid` the cycle after accept; no `mem_req`.
- Timeout: `mem_req` high exactly `TIMEOUT` cycles, then RESP with `rsp_err`=1, `rsp_rdata`=0.
- `req_valid` is ignored while `req_ready`=0; upstream holds its op under `stall`.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: LH/LHU/SH with `a[0]`=1, or LW/SW with `a[1:0]`≠0 → error response, no bus access.
- Undefined: misaligned halves force `a[0]`=0, words force `a[1:0]`=0; access proceeds, `rsp_err`=0.

## Structure
- Shared package `lsu_pkg`: funct3 constants (LB…LHU, SB/SH/SW), FSM state encoding, TIMEOUT counter width (8).
- Sub-module `lsu_align` (combinational): store lane replication + byte enables, load lane select + extension; instantiated once, unit-testable alone.

## Test plan
- SB addr 0x103, wdata 0x000000A5, ack after 2 wait cycles → `mem_addr`=0x100, `mem_be`=1000, `mem_wdata`=0xA5A5A5A5, `rsp_valid` with `rsp_we`=0.
- LB addr 0x102, `mem_rdata`=0x12_80_34_56, zero-wait ack → `rsp_rdata`=0xFFFFFF80, `rsp_we`=1, `rsp_rd` = captured rd; LBU same → 0x00000080.
- LH addr 0x202, `mem_rdata`=0xBEEF1234 → 0xFFFFBEEF; LHU → 0x0000BEEF; LW → 0xBEEF1234; each rsp 2 cycles after accept.
- Load, no ack, TIMEOUT=16 → `mem_req` high 16 cycles, then `rsp_err`=1, `rsp_we`=0; ack pulse one cycle later ignored, `req_ready`=1.
- LW addr 0x101: with macro → err next cycle, `mem_req` never asserted; without → `mem_addr`=0x100, `mem_be`=1111, normal response.
- funct3=011 load → immediate err; `rst` during BUS → `mem_req`=0 and no `rsp_valid` after the reset edge.
